// File: rtl/dense_layer_mac.sv
// Dense layer MAC: walks every neuron row from the weight ROM, accumulates LANES
// products per cycle against the held activation vector, emits ReLU-requantized results.
module dense_layer_mac #(
    parameter int NUM_NEURONS = 30,
    parameter int NUM_INPUTS  = 432,
    parameter int LANES       = 8,
    parameter int ACC_W       = 24,
    parameter int SHIFT       = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_INPUTS*8-1:0]        in_vec_flat,
    output logic [$clog2(NUM_NEURONS)-1:0] neuron_index,
    input  logic [NUM_INPUTS*8-1:0]        neuron_weights_flat,
    output logic                           busy,
    output logic                           out_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] out_index,
    output logic [7:0]                     out_data,
    output logic                           done
);

    localparam int IDX_W   = $clog2(NUM_NEURONS);
    localparam int CHUNKS  = NUM_INPUTS / LANES;
    localparam int CHUNK_W = $clog2(CHUNKS + 1);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, EMIT, DONE} state_t;

    state_t                   state_q;
    logic [IDX_W-1:0]         neuron_index_q;
    logic [IDX_W-1:0]         out_index_q;
    logic [7:0]               out_data_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [CHUNK_W-1:0]       chunk_q;
    logic                     busy_q;
    logic                     out_valid_q;
    logic                     done_q;

    logic signed [ACC_W-1:0]  chunk_sum;
    logic signed [7:0]        act;
    logic signed [7:0]        wgt;
    logic signed [15:0]       prod;

    // Floor shift, then clamp to the non-negative signed 8-bit range.
    function automatic logic [7:0] relu_requant(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = v >>> SHIFT;
        if (r < 0)
            return 8'd0;
        else if (r > 127)
            return 8'd127;
        else
            return r[7:0];
    endfunction

    always_comb begin
        chunk_sum = '0;
        act       = '0;
        wgt       = '0;
        prod      = '0;
        for (int l = 0; l < LANES; l++) begin
            act       = signed'(in_vec_flat[8*(int'(chunk_q)*LANES + l) +: 8]);
            wgt       = signed'(neuron_weights_flat[8*(int'(chunk_q)*LANES + l) +: 8]);
            prod      = act * wgt;
            chunk_sum = chunk_sum + ACC_W'(prod);
        end
        acc_d = acc_q + chunk_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            neuron_index_q <= '0;
            out_index_q    <= '0;
            out_data_q     <= '0;
            acc_q          <= '0;
            chunk_q        <= '0;
            busy_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= FETCH;
                        neuron_index_q <= '0;
                        busy_q         <= 1'b1;
                    end
                end
                FETCH: begin
                    // The ROM latches neuron_index on this edge; its row is ready for chunk 0.
                    acc_q   <= '0;
                    chunk_q <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (chunk_q == CHUNK_W'(CHUNKS - 1)) begin
                        chunk_q     <= '0;
                        out_data_q  <= relu_requant(acc_d);
                        out_valid_q <= 1'b1;
                        out_index_q <= neuron_index_q;
                        state_q     <= EMIT;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                EMIT: begin
                    out_valid_q <= 1'b0;
                    if (neuron_index_q == IDX_W'(NUM_NEURONS - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        neuron_index_q <= neuron_index_q + 1'b1;
                        state_q        <= FETCH;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign neuron_index = neuron_index_q;
    assign out_index    = out_index_q;
    assign out_data     = out_data_q;
    assign busy         = busy_q;
    assign out_valid    = out_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_dense_layer_mac.sv
// Randomized bench for dense_layer_mac with a registered weight ROM and a
// plain-arithmetic reference model of each neuron's requantized output.
module tb_dense_layer_mac;

    localparam int NN     = 30;
    localparam int NI     = 432;
    localparam int LANES  = 8;
    localparam int CHUNKS = NI / LANES;
    localparam int PERIOD = CHUNKS + 2;
    localparam int LAT    = CHUNKS + 1;
    localparam int DONE_J = LAT + PERIOD*(NN-1) + 1;
    localparam int IW     = $clog2(NN);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NI*8-1:0]   in_vec_flat;
    logic [IW-1:0]     neuron_index;
    logic [NI*8-1:0]   neuron_weights_flat;
    logic              busy;
    logic              out_valid;
    logic [IW-1:0]     out_index;
    logic [7:0]        out_data;
    logic              done;

    byte               xv [NI];
    byte               wv [NN][NI];
    logic [NI*8-1:0]   rom_flat [NN];
    int                exp_out [NN];
    int                got_out [NN];
    int                n_checks;
    int                n_errors;

    dense_layer_mac #(
        .NUM_NEURONS(NN), .NUM_INPUTS(NI), .LANES(LANES), .ACC_W(24), .SHIFT(7)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .in_vec_flat         (in_vec_flat),
        .neuron_index        (neuron_index),
        .neuron_weights_flat (neuron_weights_flat),
        .busy                (busy),
        .out_valid           (out_valid),
        .out_index           (out_index),
        .out_data            (out_data),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight ROM with one cycle of read latency.
    always @(posedge clk) neuron_weights_flat <= rom_flat[neuron_index];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vectors();
        for (int i = 0; i < NI; i++) in_vec_flat[8*i +: 8] = xv[i];
        for (int n = 0; n < NN; n++) begin
            int s;
            int r;
            s = 0;
            for (int i = 0; i < NI; i++) begin
                rom_flat[n][8*i +: 8] = wv[n][i];
                s += int'(xv[i]) * int'(wv[n][i]);
            end
            r = s >>> 7;
            exp_out[n] = (r < 0) ? 0 : ((r > 127) ? 127 : r);
        end
    endtask

    task automatic randomize_vectors(input int wspan);
        for (int i = 0; i < NI; i++) xv[i] = byte'($urandom_range(255));
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
                wv[n][i] = byte'(int'($urandom_range(2*wspan)) - wspan);
    endtask

    task automatic run_layer(input bit noisy);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idx_after_start", 32'(neuron_index), 32'd0);
        for (int j = 0; j <= DONE_J + 6; j++) begin
            bit ev;
            int n;
            ev = (j >= LAT) && ((j - LAT) % PERIOD == 0) && ((j - LAT) / PERIOD < NN);
            n  = (j - LAT) / PERIOD;
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("done", 32'(done), 32'(j == DONE_J));
            chk("busy", 32'(busy), 32'(j <= DONE_J));
            if (ev) begin
                chk("out_index", 32'(out_index), 32'(n));
                chk("out_data", 32'(out_data), 32'(exp_out[n]));
                got_out[n] = int'(out_data);
            end
            if (noisy && j < DONE_J)
                start = ($urandom_range(3) == 0);
            else
                start = noisy && (j == DONE_J);
            tick();
        end
        start = 1'b0;
        chk("idx_hold", 32'(neuron_index), 32'(NN - 1));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        randomize_vectors(127);
        load_vectors();

        // Reset held with start asserted and random inputs.
        repeat (4) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_oidx", 32'(out_index), 32'd0);
        chk("rst_nidx", 32'(neuron_index), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Unit inputs: row 0 all +1, row 1 all -1.
        randomize_vectors(4);
        for (int i = 0; i < NI; i++) begin
            xv[i]    = 8'sd1;
            wv[0][i] = 8'sd1;
            wv[1][i] = -8'sd1;
        end
        load_vectors();
        run_layer(1'b0);
        chk("n0_plus_ones", 32'(got_out[0]), 32'd3);
        chk("n1_relu_zero", 32'(got_out[1]), 32'd0);

        // Saturating row.
        randomize_vectors(127);
        for (int i = 0; i < NI; i++) begin
            xv[i]    = 8'sd127;
            wv[2][i] = 8'sd127;
        end
        load_vectors();
        run_layer(1'b0);
        chk("n2_saturate", 32'(got_out[2]), 32'd127);

        // Fully random layer with stray start pulses.
        randomize_vectors(4);
        load_vectors();
        run_layer(1'b1);

        // Abort while neuron 5 is accumulating, then restart from neuron 0.
        randomize_vectors(4);
        load_vectors();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) tick();
        chk("abort_idx", 32'(neuron_index), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_nidx", 32'(neuron_index), 32'd0);
        chk("abort_oidx", 32'(out_index), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_abort_busy", 32'(busy), 32'd0);
        run_layer(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
